// File: rtl/byte_unstripping_n.sv
// N-lane byte unstripper: per-lane FIFOs drained in strict round-robin onto a valid/ready output.
// Define BYTE_UNSTRIP_ALIGN_EN to hold the first pop until every lane FIFO holds a word.
module byte_unstripping_n #(
    parameter int unsigned LANES = 2,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_f,
    input  logic                     reset_L,
    input  logic [LANES*WIDTH-1:0]   data_stripe,
    input  logic [LANES-1:0]         valid_stripe,
    input  logic                     ready_demux,
    output logic [WIDTH-1:0]         data_demux,
    output logic                     valid_demux,
    output logic [LANES-1:0]         lane_full,
    output logic                     overflow_err,
    output logic [$clog2(LANES)-1:0] lane_sel
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = $clog2(LANES);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] mem    [LANES][DEPTH];
    logic [PW-1:0]    wr_ptr [LANES];
    logic [PW-1:0]    rd_ptr [LANES];
    logic [PW-1:0]    wr_nxt [LANES];
    logic [PW-1:0]    rd_nxt [LANES];
    logic [LANES-1:0] empty, full, push, pop_lane, full_nxt;
    logic             free, start, pop, drop;
    logic [SW-1:0]    sel_nxt;
    logic [WIDTH-1:0] head;

    always_comb begin
        empty     = '0;
        full      = '0;
        push      = '0;
        pop_lane  = '0;
        full_nxt  = '0;
        drop      = 1'b0;
        state_nxt = state;
        sel_nxt   = lane_sel;
        for (int unsigned i = 0; i < LANES; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
`ifdef BYTE_UNSTRIP_ALIGN_EN
        start = &(~empty);
`else
        start = !empty[0];
`endif
        free = !valid_demux || ready_demux;
        pop  = ((state == RUN) || start) && !empty[lane_sel] && free;
        head = mem[lane_sel][rd_ptr[lane_sel][AW-1:0]];
        if (pop) begin
            pop_lane[lane_sel] = 1'b1;
            sel_nxt            = lane_sel + SW'(1);
        end
        // A full lane still accepts a push when it is being popped in the same cycle.
        for (int unsigned i = 0; i < LANES; i++) begin
            push[i]     = valid_stripe[i] && (!full[i] || pop_lane[i]);
            drop        = drop | (valid_stripe[i] && full[i] && !pop_lane[i]);
            wr_nxt[i]   = wr_ptr[i] + PW'(push[i]);
            rd_nxt[i]   = rd_ptr[i] + PW'(pop_lane[i]);
            full_nxt[i] = (wr_nxt[i][AW] != rd_nxt[i][AW]) &&
                          (wr_nxt[i][AW-1:0] == rd_nxt[i][AW-1:0]);
        end
        case (state)
            IDLE:    if (pop) state_nxt = RUN;
            RUN:     if (!pop && lane_sel == '0 && empty[0]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            state        <= IDLE;
            lane_sel     <= '0;
            data_demux   <= '0;
            valid_demux  <= 1'b0;
            lane_full    <= '0;
            overflow_err <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            lane_sel  <= sel_nxt;
            lane_full <= full_nxt;
            if (drop)
                overflow_err <= 1'b1;
            for (int unsigned i = 0; i < LANES; i++) begin
                wr_ptr[i] <= wr_nxt[i];
                rd_ptr[i] <= rd_nxt[i];
            end
            if (pop) begin
                data_demux  <= head;
                valid_demux <= 1'b1;
            end else if (free) begin
                valid_demux <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_f) begin
        for (int unsigned i = 0; i < LANES; i++)
            if (push[i])
                mem[i][wr_ptr[i][AW-1:0]] <= data_stripe[i*WIDTH +: WIDTH];
    end

endmodule

// File: tb/tb_byte_unstripping_n.sv
// Bench for byte_unstripping_n: directed 2-lane and 4-lane sequences plus randomized 4-lane run against a queue model.
module tb_byte_unstripping_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [15:0] ds2;
    logic [1:0]  vs2;
    logic        rdy2;
    logic [7:0]  dd2;
    logic        vd2;
    logic [1:0]  lf2;
    logic        ov2;
    logic [0:0]  sel2;

    logic [31:0] ds4;
    logic [3:0]  vs4;
    logic        rdy4;
    logic [7:0]  dd4;
    logic        vd4;
    logic [3:0]  lf4;
    logic        ov4;
    logic [1:0]  sel4;

    byte_unstripping_n #(.LANES(2), .WIDTH(8), .DEPTH(4)) u_dut2 (
        .clk_f(clk), .reset_L(rst_n), .data_stripe(ds2), .valid_stripe(vs2),
        .ready_demux(rdy2), .data_demux(dd2), .valid_demux(vd2),
        .lane_full(lf2), .overflow_err(ov2), .lane_sel(sel2));

    byte_unstripping_n #(.LANES(4), .WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk_f(clk), .reset_L(rst_n), .data_stripe(ds4), .valid_stripe(vs4),
        .ready_demux(rdy4), .data_demux(dd4), .valid_demux(vd4),
        .lane_full(lf4), .overflow_err(ov4), .lane_sel(sel4));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] vs;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic       exp_v;
        logic [7:0] exp_d;
        logic       exp_sel;
    } vec_t;
    vec_t tbl [6];

    // Reference model for the 4-lane instance: per-lane queues drained round-robin.
    logic [7:0] mq [4][$];
    int         m_sel;
    bit         m_run;
    bit         m_valid;
    logic [7:0] m_data;
    bit         m_ovf;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_sel = 0; m_run = 0; m_valid = 0; m_data = 8'h00; m_ovf = 0;
    endtask

    task automatic model_step(input logic [3:0] vs, input logic [31:0] d, input logic rdy);
        bit free, start, pop;
        free = !m_valid || rdy;
`ifdef BYTE_UNSTRIP_ALIGN_EN
        start = (mq[0].size() > 0) && (mq[1].size() > 0) && (mq[2].size() > 0) && (mq[3].size() > 0);
`else
        start = (mq[0].size() > 0);
`endif
        pop = (m_run || start) && (mq[m_sel].size() > 0) && free;
        if (pop) begin
            m_data  = mq[m_sel].pop_front();
            m_valid = 1;
            m_sel   = (m_sel + 1) % 4;
            m_run   = 1;
        end else begin
            if (free) m_valid = 0;
            if (m_sel == 0 && mq[0].size() == 0) m_run = 0;
        end
        for (int i = 0; i < 4; i++)
            if (vs[i]) begin
                if (mq[i].size() < 4) mq[i].push_back(d[i*8 +: 8]);
                else m_ovf = 1;
            end
    endtask

    task automatic check4(input string tag);
        logic [3:0] exp_full;
        for (int i = 0; i < 4; i++) exp_full[i] = (mq[i].size() == 4);
        chk({tag, "_valid"}, {31'd0, vd4}, {31'd0, m_valid});
        chk({tag, "_data"},  {24'd0, dd4}, {24'd0, m_data});
        chk({tag, "_sel"},   {30'd0, sel4}, m_sel);
        chk({tag, "_full"},  {28'd0, lf4}, {28'd0, exp_full});
        chk({tag, "_ovf"},   {31'd0, ov4}, {31'd0, m_ovf});
    endtask

    logic [1:0] sk_vs [6];
    logic [7:0] sk_d0 [6];
    logic [7:0] sk_d1 [6];
    logic       sk_v  [6];
    logic [7:0] sk_d  [6];

    initial begin
        rst_n = 1'b0;
        ds2 = '0; vs2 = '0; rdy2 = 1'b1;
        ds4 = '0; vs4 = '0; rdy4 = 1'b1;
        #12;
        chk("rst_valid2", {31'd0, vd2}, 0);
        chk("rst_data2",  {24'd0, dd2}, 0);
        chk("rst_full2",  {30'd0, lf2}, 0);
        chk("rst_ovf2",   {31'd0, ov2}, 0);
        chk("rst_sel2",   {31'd0, sel2}, 0);
        chk("rst_valid4", {31'd0, vd4}, 0);
        chk("rst_sel4",   {30'd0, sel4}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{2'b11, 8'hA0, 8'hA1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{2'b11, 8'hB0, 8'hB1, 1'b1, 1'b1, 8'hA0, 1'b1};
        tbl[2] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b0};
        tbl[3] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hB0, 1'b1};
        tbl[4] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hB1, 1'b0};
        tbl[5] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'hB1, 1'b0};
        for (int v = 0; v < 6; v++) begin
            vs2 = tbl[v].vs; ds2 = {tbl[v].d1, tbl[v].d0}; rdy2 = tbl[v].rdy;
            tick();
            chk($sformatf("basic%0d_valid", v), {31'd0, vd2}, {31'd0, tbl[v].exp_v});
            chk($sformatf("basic%0d_data", v),  {24'd0, dd2}, {24'd0, tbl[v].exp_d});
            chk($sformatf("basic%0d_sel", v),   {31'd0, sel2}, {31'd0, tbl[v].exp_sel});
        end

        // Overflow: lane 1 only, no lane 0 data so nothing drains.
        rdy2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            vs2 = 2'b10; ds2 = {8'(8'h60 + k), 8'h00};
            tick();
            chk($sformatf("ovf_w%0d_full", k), {30'd0, lf2}, (k >= 4) ? 32'd2 : 32'd0);
            chk($sformatf("ovf_w%0d_err", k),  {31'd0, ov2}, (k >= 5) ? 32'd1 : 32'd0);
        end
        vs2 = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ovf_sticky", {31'd0, ov2}, 1);
            chk("ovf_full_hold", {30'd0, lf2}, 2);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("ovf_clear_err",  {31'd0, ov2}, 0);
        chk("ovf_clear_full", {30'd0, lf2}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Skew: lane 1 word arrives two cycles after lane 0.
        rdy2 = 1'b1;
        sk_vs = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        sk_d0 = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sk_d1 = '{8'h00, 8'h00, 8'hC1, 8'h00, 8'h00, 8'h00};
`ifdef BYTE_UNSTRIP_ALIGN_EN
        sk_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        sk_d = '{8'h00, 8'h00, 8'h00, 8'hC0, 8'hC1, 8'hC1};
`else
        sk_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        sk_d = '{8'h00, 8'hC0, 8'hC0, 8'hC1, 8'hC1, 8'hC1};
`endif
        for (int v = 0; v < 6; v++) begin
            vs2 = sk_vs[v]; ds2 = {sk_d1[v], sk_d0[v]};
            tick();
            chk($sformatf("skew%0d_valid", v), {31'd0, vd2}, {31'd0, sk_v[v]});
            chk($sformatf("skew%0d_data", v),  {24'd0, dd2}, {24'd0, sk_d[v]});
        end

        // Async reset while lane 1 is next and a word is on the output.
        vs2 = 2'b11; ds2 = {8'h22, 8'h11};
        tick();
        vs2 = 2'b00;
        tick();
        chk("mid_pre_valid", {31'd0, vd2}, 1);
        chk("mid_pre_sel",   {31'd0, sel2}, 1);
        chk("mid_pre_data",  {24'd0, dd2}, 32'h11);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, vd2}, 0);
        chk("mid_rst_data",  {24'd0, dd2}, 0);
        chk("mid_rst_sel",   {31'd0, sel2}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        vs2 = 2'b11; ds2 = {8'h66, 8'h55};
        tick();
        chk("mid_post0_valid", {31'd0, vd2}, 0);
        vs2 = 2'b00;
        tick();
        chk("mid_post1_valid", {31'd0, vd2}, 1);
        chk("mid_post1_data",  {24'd0, dd2}, 32'h55);
        tick();
        chk("mid_post2_data",  {24'd0, dd2}, 32'h66);
        chk("mid_post2_sel",   {31'd0, sel2}, 0);
        tick();
        chk("mid_post3_valid", {31'd0, vd2}, 0);

        // Backpressure on the 4-lane instance.
        rdy4 = 1'b1; vs4 = 4'hF; ds4 = 32'h13121110;
        tick();
        chk("bp_first_valid", {31'd0, vd4}, 0);
        vs4 = 4'h0;
        tick();
        chk("bp_out0_data", {24'd0, dd4}, 32'h10);
        chk("bp_out0_sel",  {30'd0, sel4}, 1);
        rdy4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_stall_valid", {31'd0, vd4}, 1);
            chk("bp_stall_data",  {24'd0, dd4}, 32'h10);
            chk("bp_stall_sel",   {30'd0, sel4}, 1);
        end
        rdy4 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("bp_out%0d_valid", k), {31'd0, vd4}, 1);
            chk($sformatf("bp_out%0d_data", k),  {24'd0, dd4}, 32'h10 + k);
            chk($sformatf("bp_out%0d_sel", k),   {30'd0, sel4}, (k + 1) % 4);
        end
        tick();
        chk("bp_drained_valid", {31'd0, vd4}, 0);

        // Randomized 4-lane run against the queue model.
        #2 rst_n = 1'b0;
        vs4 = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                vs4 = '0;
                model_reset();
                #1;
                check4("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int l = 0; l < 4; l++) vs4[l] = ($urandom_range(0, 4) == 0);
            ds4  = $urandom;
            rdy4 = ($urandom_range(0, 5) != 0);
            model_step(vs4, ds4, rdy4);
            tick();
            check4("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_unstripping_n.md
# byte_unstripping_n

Parametrised N-lane byte unstripper for the receive side. It sits between the per-lane receivers and the data demux. Each lane's valid bytes are buffered in a private FIFO, and the original byte stream is rebuilt by strict round-robin reads (lane 0, 1, …, LANES-1, 0, …). The output has a valid/ready handshake, and overflow is detected per lane. It generalises the two-lane byte unstripping block in lane count, data width and buffering depth, and adds backpressure.

## Interface
- LANES, 2: lane count; power of 2, range 2..8.
- WIDTH, 8: bits per lane word.
- DEPTH, 4: entries per lane FIFO; power of 2, at least 2.
- clk_f  in  1  single clock; all state updates on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_stripe  in  LANES*WIDTH  lane i occupies [i*WIDTH +: WIDTH].
- valid_stripe  in  LANES  bit i qualifies lane i for the current cycle.
- ready_demux  in  1  downstream accepts data_demux this cycle.
- data_demux  out  WIDTH  reassembled word.
- valid_demux  out  1  data_demux is valid.
- lane_full  out  LANES  bit i is high while FIFO i holds DEPTH entries.
- overflow_err  out  1  sticky; a word was dropped.
- lane_sel  out  $clog2(LANES)  round-robin pointer, i.e. the lane to be read next.

## Operation
- **Reset (async assert, sync release).**
  - All FIFOs empty; lane_sel=0; state IDLE.
  - Outputs: data_demux=0, valid_demux=0, lane_full=0, overflow_err=0.
- **Lane write.** When valid_stripe[i]=1, data_stripe lane i is pushed into FIFO i.
  - Push to a full FIFO with no pop from that FIFO in the same cycle: the word is dropped, FIFO contents are unchanged, and overflow_err is set.
  - Full FIFO with a pop in the same cycle: push and pop both occur.
- **Output stage.** data_demux and valid_demux are registered.
  - free = !valid_demux || ready_demux.
  - pop = (state RUN or start condition) && FIFO[lane_sel] non-empty && free.
  - On pop: data_demux <= head of FIFO[lane_sel]; valid_demux <= 1; lane_sel <= lane_sel+1, wrapping LANES-1 -> 0.
  - free && !pop: valid_demux <= 0. data_demux holds its last value.
  - valid_demux && !ready_demux: data_demux and valid_demux are held unchanged.
- **No lane skipping.** If FIFO[lane_sel] is empty, output stalls even when other lanes hold data. Byte order is preserved.
- **State machine.**
  - IDLE: no pops until the start condition holds. When it does, pop in the same cycle and go to RUN.
  - RUN: pop per the rule above. Go to IDLE when lane_sel=0, FIFO[0] is empty and no pop occurs this cycle.
  - Start condition: FIFO[0] non-empty. It becomes "all FIFOs non-empty" under the macro below.
- **FIFO pointers.** Width $clog2(DEPTH)+1 so full and empty are distinguishable; the MSB flips on wrap.
- **overflow_err** clears only on reset.

## Timing
- **Latency.** A word on lane 0, sampled at edge k into an empty design, appears on data_demux/valid_demux after edge k+1.
- **Throughput.** One output word per cycle while the head lane is non-empty and ready_demux=1.
  - A full group of LANES words drains in LANES cycles.
- **lane_full.** Registered; reflects occupancy after each edge.
- **Reset mid-operation.** Asynchronous reset clears everything immediately. In-flight words are lost, and the first word after release is read from lane 0.

## Configuration
- **BYTE_UNSTRIP_ALIGN_EN defined:**
  - The start condition requires every lane FIFO to be non-empty.
  - The first lane 0 pop is deferred until every lane holds a word. This absorbs inter-lane skew of up to DEPTH-1 cycles.
- **Undefined:** output starts as soon as FIFO[0] is non-empty. Later lanes are waited for individually by the stall rule.

## Test plan
- **Basic reassembly.** LANES=2, ready_demux=1.
  - Stimulus: cycle 0 lanes {0xA0, 0xA1}; cycle 1 {0xB0, 0xB1}.
  - Required: data_demux sequence A0, A1, B0, B1 on consecutive cycles, with the first one cycle after the sample edge; then valid_demux=0 and state IDLE.
- **Backpressure.** LANES=4.
  - Stimulus: one group 0x10..0x13, with ready_demux=0 for 3 cycles after the first valid.
  - Required: data_demux holds 0x10 with valid_demux=1 during the stall; 0x11..0x13 follow once ready_demux=1; no loss.
- **Overflow.** DEPTH=4, ready_demux=0.
  - Stimulus: 6 consecutive writes on lane 1.
  - Required: lane_full[1]=1 after the 4th write; the 5th and 6th words are dropped; overflow_err=1 and stays 1 until reset_L=0.
- **Skew with BYTE_UNSTRIP_ALIGN_EN.**
  - Stimulus: lane 1 arrives 2 cycles after lane 0.
  - Required: no valid_demux until both FIFOs are non-empty; output order lane0, lane1.
  - Without the macro: output 0 appears immediately, then a stall until lane 1 arrives.
- **Async reset mid-stream.**
  - Stimulus: assert reset_L=0 between edges while valid_demux=1 and lane_sel=1.
  - Required: outputs go to 0 immediately; after release a new group {0x55, 0x66} outputs 0x55 first.
